// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-bit ripple slice reused
// NDIG times per operation, LSB digit first, with a start/done handshake.
`timescale 1ns/1ps
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iCin,
    input  logic             iSub,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oSum,
    output logic             oCout,
    output logic             oOvf
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_addsub: WIDTH must be an exact multiple of DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic              c_q, c_d, sub_q, sub_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic [DIGIT:0]    carry;
    logic [DIGIT-1:0]  dsum;
    logic [WIDTH-1:0]  res_next;
    logic              last;

    // Ripple through one digit; carry[DIGIT-1] is the carry into the digit's MSB.
    always_comb begin
        carry    = '0;
        dsum     = '0;
        carry[0] = c_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            dsum[i]    = a_q[i] ^ b_q[i] ^ carry[i];
            carry[i+1] = (a_q[i] & b_q[i]) | (carry[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // New digit enters at the top so the result lands aligned after NDIG shifts.
    assign res_next = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    assign last     = (cnt_q == CNTW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (iStart) begin
                    a_d     = iA;
                    b_d     = iSub ? ~iB : iB;
                    c_d     = iSub ? ~iCin : iCin;
                    sub_d   = iSub;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                c_d   = carry[DIGIT];
                res_d = res_next;
                cnt_d = cnt_q + CNTW'(1);
                if (last) begin
                    sum_d   = res_next;
                    cout_d  = sub_q ^ carry[DIGIT];
                    ovf_d   = carry[DIGIT] ^ carry[DIGIT-1];
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oBusy = (state_q == StRun);
    assign oDone = (state_q == StDone);
    assign oSum  = sum_q;
    assign oCout = cout_q;
    assign oOvf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: four instances (DIGIT = 1, 2, 4, 8) at WIDTH = 8,
// a driver pushing expected results and a negedge monitor popping them on oDone.
`timescale 1ns/1ps
module tb_serial_addsub;

    localparam int NI = 4;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic         start_s [NI];
    logic [W-1:0] a_s     [NI];
    logic [W-1:0] b_s     [NI];
    logic         cin_s   [NI];
    logic         sub_s   [NI];
    logic         busy_s  [NI];
    logic         done_s  [NI];
    logic [W-1:0] sum_s   [NI];
    logic         cout_s  [NI];
    logic         ovf_s   [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_addsub #(.WIDTH(W), .DIGIT(1 << g)) u_dut (
            .iClk   (clk),
            .iRst   (rst),
            .iStart (start_s[g]),
            .iA     (a_s[g]),
            .iB     (b_s[g]),
            .iCin   (cin_s[g]),
            .iSub   (sub_s[g]),
            .oBusy  (busy_s[g]),
            .oDone  (done_s[g]),
            .oSum   (sum_s[g]),
            .oCout  (cout_s[g]),
            .oOvf   (ovf_s[g])
        );
    end

    typedef struct {
        int         inst;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         done_cyc;
    } exp_t;

    exp_t       scb [$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] hold_sum  [NI];
    logic       hold_cout [NI];
    logic       hold_ovf  [NI];
    int         busy_cnt  [NI];

    function automatic int ndig(int i);
        return W >> i;
    endfunction

    task automatic chk(string name, int i, logic [31:0] got, logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s inst%0d (DIGIT=%0d): got 0x%0h, required 0x%0h @%0t",
                     name, i, 1 << i, got, req, $time);
        end
    endtask

    // Independent integer reference for the random phase.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, output logic [7:0] s, output logic co,
                         output logic ov);
        int ua, ub, sa, sb, u, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            u  = ua + ub + int'(cin);
            r  = sa + sb + int'(cin);
            co = (u > 255);
        end else begin
            u  = ua - ub - int'(cin);
            r  = sa - sb - int'(cin);
            co = (u < 0);
        end
        s  = u[7:0];
        ov = (r > 127) || (r < -128);
    endtask

    // Call at a negedge: drive a start and record the completion it must produce.
    task automatic launch(int i, logic [7:0] a, logic [7:0] b, logic cin, logic sub,
                          logic [7:0] es, logic ec, logic eo);
        a_s[i]     = a;
        b_s[i]     = b;
        cin_s[i]   = cin;
        sub_s[i]   = sub;
        start_s[i] = 1'b1;
        scb.push_back('{i, es, ec, eo, cyc + 1 + ndig(i)});
    endtask

    task automatic drain(int budget);
        int  n;
        bool_busy: begin end
        n = 0;
        while ((scb.size() != 0 || busy_s[0] || busy_s[1] || busy_s[2] || busy_s[3])
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 0, scb.size(), 0);
        scb.delete();
    endtask

    task automatic run_all(logic [7:0] a, logic [7:0] b, logic cin, logic sub,
                           logic [7:0] es, logic ec, logic eo);
        @(negedge clk);
        for (int i = 0; i < NI; i++) launch(i, a, b, cin, sub, es, ec, eo);
        @(negedge clk);
        for (int i = 0; i < NI; i++) start_s[i] = 1'b0;
        drain(40);
    endtask

    task automatic check_zero(string name);
        for (int i = 0; i < NI; i++) begin
            chk({name, "_busy"}, i, busy_s[i], 0);
            chk({name, "_done"}, i, done_s[i], 0);
            chk({name, "_sum"},  i, sum_s[i],  0);
            chk({name, "_cout"}, i, cout_s[i], 0);
            chk({name, "_ovf"},  i, ovf_s[i],  0);
        end
    endtask

    always @(negedge clk) begin
        int   k;
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (done_s[i]) begin
                k = -1;
                for (int j = 0; j < scb.size(); j++)
                    if (k < 0 && scb[j].inst == i) k = j;
                if (k < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done inst%0d: got oDone=1, required no pending op @%0t",
                             i, $time);
                end else begin
                    e = scb[k];
                    scb.delete(k);
                    chk("sum",        i, sum_s[i],    e.sum);
                    chk("cout",       i, cout_s[i],   e.cout);
                    chk("ovf",        i, ovf_s[i],    e.ovf);
                    chk("latency",    i, cyc,         e.done_cyc);
                    chk("busy_len",   i, busy_cnt[i], ndig(i));
                    chk("busy_in_done", i, busy_s[i], 0);
                    hold_sum[i]  = e.sum;
                    hold_cout[i] = e.cout;
                    hold_ovf[i]  = e.ovf;
                end
            end else begin
                chk("held_outputs", i, {sum_s[i], cout_s[i], ovf_s[i]},
                    {hold_sum[i], hold_cout[i], hold_ovf[i]});
            end
            busy_cnt[i] = busy_s[i] ? busy_cnt[i] + 1 : 0;
        end
    end

    initial begin
        logic [7:0] ra, rb, es;
        logic       rc, rs, ec, eo;
        int         c0;

        for (int i = 0; i < NI; i++) begin
            start_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; cin_s[i] = 1'b0; sub_s[i] = 1'b0;
            hold_sum[i] = '0; hold_cout[i] = 1'b0; hold_ovf[i] = 1'b0; busy_cnt[i] = 0;
        end
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Directed: a, b, cin, sub -> sum, cout, ovf (hand-computed)
        run_all(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_all(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run_all(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
        run_all(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
        run_all(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        run_all(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_all(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
        run_all(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);

        // Start pulse with new operands mid-RUN must be ignored.
        @(negedge clk);
        launch(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        a_s[0] = 8'hFF; b_s[0] = 8'hFF; sub_s[0] = 1'b1; cin_s[0] = 1'b1; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        drain(40);

        // Start held through DONE: second op begins with no IDLE cycle.
        @(negedge clk);
        c0 = cyc;
        launch(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        @(negedge clk);
        a_s[0] = 8'h05; b_s[0] = 8'h07; cin_s[0] = 1'b0; sub_s[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("hold_done_cycle", 0, cyc, c0 + 9);
        chk("hold_done_flag",  0, done_s[0], 1);
        scb.push_back('{0, 8'hFE, 1'b1, 1'b0, cyc + 1 + ndig(0)});
        @(negedge clk);
        start_s[0] = 1'b0;
        drain(40);

        // Asynchronous reset during digit 3 of 8 discards the op.
        @(negedge clk);
        launch(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        scb.delete();
        for (int i = 0; i < NI; i++) begin
            hold_sum[i] = '0; hold_cout[i] = 1'b0; hold_ovf[i] = 1'b0;
        end
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_all(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);

        // Random operands on all four digit widths against the integer model.
        repeat (1000) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rc, rs, es, ec, eo);
            run_all(ra, rb, rc, rs, es, ec, eo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
